// File: rtl/snoopy_sprite_drawer.sv
// Snoopy sprite redraw engine: erases the sprite at its previous column,
// then draws it at the newly captured column, one VGA pixel per cycle.
module snoopy_sprite_drawer #(
  parameter int         SPRITE_W  = 8,
  parameter int         SPRITE_H  = 8,
  parameter int         SNOOPY_Y  = 100,
  parameter int         SCREEN_W  = 160,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [2:0] FG_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] snoopy_x,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam int XB = $clog2(SPRITE_W);
  localparam int CW = $clog2(SPRITE_W * SPRITE_H);
  localparam int YB = CW - XB;

  localparam logic [CW-1:0] LAST = {CW{1'b1}};
  localparam logic [8:0]    SCR  = 9'(SCREEN_W);
  localparam logic [6:0]    TOP  = 7'(SNOOPY_Y);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [7:0]    old_q;
  logic [7:0]    old_d;
  logic [7:0]    new_q;
  logic [7:0]    new_d;

  logic [XB-1:0] col;
  logic [YB-1:0] row;
  logic          active;
  logic          drawing;
  logic          on_screen;
  logic [7:0]    base_x;
  logic [7:0]    px_x;
  logic [6:0]    px_y;
  logic [2:0]    px_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      old_q   <= '0;
      new_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      old_q   <= old_d;
      new_q   <= new_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    old_d   = old_q;
    new_d   = new_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          new_d   = snoopy_x;
          cnt_d   = '0;
          state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        old_d   = new_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Raster order: low counter bits walk the columns.
  assign col = cnt_q[XB-1:0];
  assign row = cnt_q[CW-1:XB];

  always_comb begin
    active    = (state_q == S_ERASE) || (state_q == S_DRAW);
    drawing   = (state_q == S_DRAW);
    base_x    = drawing ? new_q : old_q;
    px_x      = base_x + 8'(col);
    px_y      = TOP + 7'(row);
    px_c      = drawing ? FG_COLOUR : BG_COLOUR;
    on_screen = {1'b0, px_x} < SCR;
  end

  // Clipped pixels still use their cycle; coordinates hold when not plotting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vga_plot <= active && on_screen;
      busy     <= (state_q != S_IDLE);
      done     <= (state_q == S_DONE);
      if (active && on_screen) begin
        vga_x      <= px_x;
        vga_y      <= px_y;
        vga_colour <= px_c;
      end
    end
  end

endmodule
